xm23_mem_ctrl: RTL and testbench
================================

// Module: xm23_mem_ctrl
// PURPOSE
//  Memory-access sequencer between the XM23 CPU's MAR/MDR/control-register path and the dual byte-lane RAM.
//  Accepts one word/byte read or write request at a time and drives the lane addresses, write enables and data.
//  Adds configurable wait states, then returns read data or a completion pulse.
//  Flags misaligned word accesses as faults and never sends them to memory.
// PARAMETERS
//  ADDR_W       16  byte-address width
//  WAIT_STATES  1   extra cycles between address launch and data capture (0..15)
// PORTS
//  Clock         in   1       single system clock, rising-edge
//  Reset_n       in   1       asynchronous active-low reset
//  req           in   1       request strobe; sampled only when busy=0
//  rw            in   1       0=read, 1=write
//  byte_acc      in   1       1=byte access (low lane only), 0=word
//  addr          in   ADDR_W  byte address (from MAR)
//  wdata         in   16      write data (from MDR)
//  busy          out  1       high in every state except IDLE
//  done          out  1       one-cycle completion pulse
//  fault         out  1       with done: misaligned word access, no memory cycle
//  rdata         out  16      read data, valid with done, held until next done
//  mem_lb_addr   out  ADDR_W  low-lane address
//  mem_ub_addr   out  ADDR_W  high-lane address
//  mem_lb_wdata  out  8       low-lane write data
//  mem_ub_wdata  out  8       high-lane write data
//  mem_lb_we     out  1       low-lane write enable
//  mem_ub_we     out  1       high-lane write enable
//  mem_lb_rdata  in   8       low-lane read data, 1-cycle synchronous RAM
//  mem_ub_rdata  in   8       high-lane read data
//  bkpt_addr     in   ADDR_W  breakpoint address (used only with XM23_MEM_BKPT_EN)
//  bkpt_hit      out  1       breakpoint pulse, coincident with done
// BEHAVIOUR
//  Reset values: state=IDLE; busy, done, fault, bkpt_hit, we=0; rdata, addresses, wdata=0.
//  FSM: IDLE -> LAUNCH -> WAIT (WAIT_STATES cycles; skipped if 0) -> CAPTURE -> DONE -> IDLE.
//  IDLE, req=1: latch rw, byte_acc, addr, wdata.
//   - Word access with addr[0]=1: go directly to DONE with fault=1. No enables, rdata unchanged.
//  LAUNCH: lb_addr=addr, ub_addr=addr+1 (mod 2^ADDR_W). Write enables pulse this cycle only.
//   - Word write: both lanes enabled, lb_wdata=wdata[7:0], ub_wdata=wdata[15:8].
//   - Byte write: mem_lb_we only.
//  WAIT: down-counter loaded with WAIT_STATES. Addresses held, enables low.
//  CAPTURE (reads only): word -> rdata={ub,lb}; byte -> rdata={8'h00,lb}. Writes do not change rdata.
//  DONE: done=1 for exactly one cycle, busy still 1. A req here is ignored, not queued.
//  Latency from req to done: WAIT_STATES+3 cycles for a good access; 1 cycle for a fault.
//  Address 0xFFFE word access is legal: ub_addr=0xFFFF. No wrap fault is possible, since odd word addresses already fault.
//  Reset mid-operation: return to IDLE at once. Any enable in flight deasserts. No done is produced.
// CONFIGURATION
//  XM23_MEM_BKPT_EN defined:
//   - Latched addr==bkpt_addr raises bkpt_hit together with done.
//   - A write that hits is suppressed: both enables stay 0.
//   - A read that hits completes normally.
//  XM23_MEM_BKPT_EN undefined: bkpt_hit is tied 0 and bkpt_addr is unused.
// STRUCTURE
//  xm23_pkg: FSM state encodings; access-size constants (ACC_WORD/ACC_BYTE); RW_READ/RW_WRITE.
//  Sub-module xm23_lane_steer (combinational): lane address/data/enable generation and read-data assembly.
//  The FSM and the wait counter stay in this module.
// TESTING
//  1. Word write 0xBEEF @0x0010, WAIT_STATES=1 -> lb_we=ub_we=1 one cycle, lb 0x10=EF, ub 0x11=BE; done at cycle 4.
//  2. Word read @0x0010 after test 1 -> rdata=0xBEEF with done; fault=0.
//  3. Byte write 0x1234 @0x0011, then byte read @0x0011 -> only lb_we pulses; rdata=0x0034.
//  4. Word read @0x0013 -> done+fault next cycle; no enable toggles; rdata keeps its previous value.
//  5. Reset_n low during WAIT of a word write -> outputs reset immediately; no done; memory written at most in LAUNCH.
//  6. XM23_MEM_BKPT_EN, bkpt_addr=0x00F8:
//   - Write @0x00F8 -> bkpt_hit with done; memory unchanged.
//   - Read @0x00F8 -> bkpt_hit with done; valid rdata.

Source files
------------

// File: rtl/xm23_pkg.sv
// Shared encodings for the XM23 memory-access sequencer: FSM states,
// access-size and direction constants.
package xm23_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } xm23_state_t;

    localparam logic ACC_WORD = 1'b0;
    localparam logic ACC_BYTE = 1'b1;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/xm23_lane_steer.sv
// Combinational lane steering: splits a byte address into low/high lane
// addresses, drives lane write data/enables and assembles read data.
module xm23_lane_steer
    import xm23_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              i_active,
    input  logic              i_launch,
    input  logic              i_rw,
    input  logic              i_byte_acc,
    input  logic              i_suppress,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [15:0]       i_wdata,
    input  logic [7:0]        i_lb_rdata,
    input  logic [7:0]        i_ub_rdata,
    output logic [ADDR_W-1:0] o_lb_addr,
    output logic [ADDR_W-1:0] o_ub_addr,
    output logic [7:0]        o_lb_wdata,
    output logic [7:0]        o_ub_wdata,
    output logic              o_lb_we,
    output logic              o_ub_we,
    output logic [15:0]       o_rdata
);

    always_comb begin
        o_lb_addr  = '0;
        o_ub_addr  = '0;
        o_lb_wdata = '0;
        o_ub_wdata = '0;
        o_lb_we    = 1'b0;
        o_ub_we    = 1'b0;
        if (i_active) begin
            // High lane wraps naturally at the top of the address space.
            o_lb_addr = i_addr;
            o_ub_addr = i_addr + ADDR_W'(1);
            if (i_rw == RW_WRITE) begin
                o_lb_wdata = i_wdata[7:0];
                if (i_byte_acc == ACC_WORD)
                    o_ub_wdata = i_wdata[15:8];
            end
            if (i_launch && (i_rw == RW_WRITE) && !i_suppress) begin
                o_lb_we = 1'b1;
                o_ub_we = (i_byte_acc == ACC_WORD);
            end
        end
        o_rdata = (i_byte_acc == ACC_BYTE) ? {8'h00, i_lb_rdata}
                                           : {i_ub_rdata, i_lb_rdata};
    end

endmodule

// File: rtl/xm23_mem_ctrl.sv
// XM23 memory-access sequencer: one request at a time, configurable wait
// states, misaligned-word fault. Optional breakpoint via XM23_MEM_BKPT_EN.
module xm23_mem_ctrl
    import xm23_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic              i_rw,
    input  logic              i_byte_acc,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [15:0]       i_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_fault,
    output logic [15:0]       o_rdata,
    output logic [ADDR_W-1:0] o_mem_lb_addr,
    output logic [ADDR_W-1:0] o_mem_ub_addr,
    output logic [7:0]        o_mem_lb_wdata,
    output logic [7:0]        o_mem_ub_wdata,
    output logic              o_mem_lb_we,
    output logic              o_mem_ub_we,
    input  logic [7:0]        i_mem_lb_rdata,
    input  logic [7:0]        i_mem_ub_rdata,
    input  logic [ADDR_W-1:0] i_bkpt_addr,
    output logic              o_bkpt_hit
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

    xm23_state_t             r_state;
    xm23_state_t             w_next_state;
    logic                    r_rw;
    logic                    r_byte_acc;
    logic                    r_fault;
    logic [ADDR_W-1:0]       r_addr;
    logic [15:0]             r_wdata;
    logic [15:0]             r_rdata;
    logic [WAIT_CNT_W-1:0]   r_wait_cnt;
    logic                    w_active;
    logic                    w_launch;
    logic                    w_suppress;
    logic [15:0]             w_rdata_asm;

`ifdef XM23_MEM_BKPT_EN
    logic r_bkpt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_bkpt <= 1'b0;
        else if ((r_state == ST_IDLE) && i_req)
            r_bkpt <= (i_addr == i_bkpt_addr);
    end

    // A breakpointed write never reaches memory; reads still complete.
    assign w_suppress = r_bkpt && (r_rw == RW_WRITE);
    assign o_bkpt_hit = r_bkpt && (r_state == ST_DONE);
`else
    logic w_unused_bkpt;
    assign w_unused_bkpt = ^i_bkpt_addr;
    assign w_suppress    = 1'b0;
    assign o_bkpt_hit    = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_rw       <= RW_READ;
            r_byte_acc <= ACC_WORD;
            r_fault    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == ST_IDLE) && i_req) begin
                r_rw       <= i_rw;
                r_byte_acc <= i_byte_acc;
                r_addr     <= i_addr;
                r_wdata    <= i_wdata;
                r_fault    <= (i_byte_acc == ACC_WORD) && i_addr[0];
            end
            if (r_state == ST_LAUNCH)
                r_wait_cnt <= WAIT_LOAD;
            else if (r_state == ST_WAIT)
                r_wait_cnt <= r_wait_cnt - WAIT_CNT_W'(1);
            if ((r_state == ST_CAPTURE) && (r_rw == RW_READ))
                r_rdata <= w_rdata_asm;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    if ((i_byte_acc == ACC_WORD) && i_addr[0])
                        w_next_state = ST_DONE;
                    else
                        w_next_state = ST_LAUNCH;
                end
            end
            ST_LAUNCH:  w_next_state = (WAIT_STATES == 0) ? ST_CAPTURE : ST_WAIT;
            ST_WAIT: begin
                if (r_wait_cnt == WAIT_CNT_W'(1))
                    w_next_state = ST_CAPTURE;
            end
            ST_CAPTURE: w_next_state = ST_DONE;
            ST_DONE:    w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    assign w_active = (r_state == ST_LAUNCH) || (r_state == ST_WAIT) ||
                      (r_state == ST_CAPTURE);
    assign w_launch = (r_state == ST_LAUNCH);

    assign o_busy  = (r_state != ST_IDLE);
    assign o_done  = (r_state == ST_DONE);
    assign o_fault = (r_state == ST_DONE) && r_fault;
    assign o_rdata = r_rdata;

    xm23_lane_steer #(
        .ADDR_W (ADDR_W)
    ) u_lane_steer (
        .i_active   (w_active),
        .i_launch   (w_launch),
        .i_rw       (r_rw),
        .i_byte_acc (r_byte_acc),
        .i_suppress (w_suppress),
        .i_addr     (r_addr),
        .i_wdata    (r_wdata),
        .i_lb_rdata (i_mem_lb_rdata),
        .i_ub_rdata (i_mem_ub_rdata),
        .o_lb_addr  (o_mem_lb_addr),
        .o_ub_addr  (o_mem_ub_addr),
        .o_lb_wdata (o_mem_lb_wdata),
        .o_ub_wdata (o_mem_ub_wdata),
        .o_lb_we    (o_mem_lb_we),
        .o_ub_we    (o_mem_ub_we),
        .o_rdata    (w_rdata_asm)
    );

endmodule

// File: tb/tb_xm23_mem_ctrl.sv
// Bench for xm23_mem_ctrl: byte-array RAM, byte-level reference memory,
// directed scenarios plus randomized accesses.
module tb_xm23_mem_ctrl;

    localparam int WS = 1;
    localparam logic [15:0] BKPT = 16'h00F8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        rw = 1'b0;
    logic        byte_acc = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        busy, done, fault, bkpt_hit;
    logic [15:0] rdata;
    logic [15:0] lb_addr, ub_addr;
    logic [7:0]  lb_wdata, ub_wdata;
    logic        lb_we, ub_we;
    logic [7:0]  lb_rdata = '0;
    logic [7:0]  ub_rdata = '0;

    logic [7:0]  ram     [0:65535] = '{default: 8'h00};
    logic [7:0]  ref_mem [0:65535] = '{default: 8'h00};
    logic [15:0] exp_rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int mon_lb  = 0;
    int mon_ub  = 0;

    always #5 clk = ~clk;

    xm23_mem_ctrl #(.ADDR_W(16), .WAIT_STATES(WS)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req          (req),
        .i_rw           (rw),
        .i_byte_acc     (byte_acc),
        .i_addr         (addr),
        .i_wdata        (wdata),
        .o_busy         (busy),
        .o_done         (done),
        .o_fault        (fault),
        .o_rdata        (rdata),
        .o_mem_lb_addr  (lb_addr),
        .o_mem_ub_addr  (ub_addr),
        .o_mem_lb_wdata (lb_wdata),
        .o_mem_ub_wdata (ub_wdata),
        .o_mem_lb_we    (lb_we),
        .o_mem_ub_we    (ub_we),
        .i_mem_lb_rdata (lb_rdata),
        .i_mem_ub_rdata (ub_rdata),
        .i_bkpt_addr    (BKPT),
        .o_bkpt_hit     (bkpt_hit)
    );

    // Synchronous RAM with one-cycle read latency on both lanes.
    always @(posedge clk) begin
        if (lb_we) ram[lb_addr] <= lb_wdata;
        if (ub_we) ram[ub_addr] <= ub_wdata;
        lb_rdata <= ram[lb_addr];
        ub_rdata <= ram[ub_addr];
    end

    always @(negedge clk) begin
        if (lb_we) mon_lb <= mon_lb + 1;
        if (ub_we) mon_ub <= mon_ub + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One access, checked against the reference memory model.
    task automatic access(input logic a_rw, input logic a_byte, input logic [15:0] a,
                          input logic [15:0] wd, input bit hold_in_done);
        int cyc;
        int lb0, ub0;
        bit flt, hit;
        logic [15:0] a1;
        int exp_lat, exp_lb, exp_ub;
        a1  = a + 16'd1;
        flt = !a_byte && a[0];
`ifdef XM23_MEM_BKPT_EN
        hit = (a == BKPT);
`else
        hit = 1'b0;
`endif
        exp_lat = flt ? 1 : WS + 3;
        exp_lb  = (!flt && a_rw && !hit) ? 1 : 0;
        exp_ub  = (!flt && a_rw && !hit && !a_byte) ? 1 : 0;

        @(negedge clk);
        lb0 = mon_lb;
        ub0 = mon_ub;
        req = 1'b1; rw = a_rw; byte_acc = a_byte; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end

        if (!flt && !a_rw)
            exp_rdata = a_byte ? {8'h00, ref_mem[a]} : {ref_mem[a1], ref_mem[a]};
        if (!flt && a_rw && !hit) begin
            ref_mem[a] = wd[7:0];
            if (!a_byte) ref_mem[a1] = wd[15:8];
        end

        chk("latency", cyc, exp_lat);
        chk("done_busy", busy, 1'b1);
        chk("fault", fault, flt);
        chk("bkpt_hit", bkpt_hit, hit);
        chk("rdata", rdata, exp_rdata);
        if (hold_in_done) req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        chk("done_pulse", done, 1'b0);
        chk("lb_we_cnt", mon_lb - lb0, exp_lb);
        chk("ub_we_cnt", mon_ub - ub0, exp_ub);
        if (hold_in_done) begin
            @(posedge clk); #1;
            chk("req_in_done_ignored", busy, 1'b0);
        end
    endtask

    initial begin
        logic [15:0] ra;
        logic        rr, rb;
        int          lb0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_bkpt", bkpt_hit, 1'b0);
        chk("rst_rdata", rdata, 16'h0);
        chk("rst_addrs", {lb_addr, ub_addr}, 32'h0);
        chk("rst_we", {lb_we, ub_we}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        access(1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b0);
        chk("ram_10", ram[16'h0010], 8'hEF);
        chk("ram_11", ram[16'h0011], 8'hBE);
        access(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0);
        chk("read_beef", rdata, 16'hBEEF);
        access(1'b1, 1'b1, 16'h0011, 16'h1234, 1'b0);
        access(1'b0, 1'b1, 16'h0011, 16'h0000, 1'b0);
        chk("read_byte", rdata, 16'h0034);
        access(1'b0, 1'b0, 16'h0013, 16'h0000, 1'b0);
        chk("fault_keeps_rdata", rdata, 16'h0034);
        access(1'b1, 1'b0, 16'hFFFE, 16'hC0DE, 1'b0);
        access(1'b0, 1'b0, 16'hFFFE, 16'h0000, 1'b1);
        chk("read_top", rdata, 16'hC0DE);

        // Reset while the word write sits in WAIT.
        @(negedge clk);
        lb0 = mon_lb;
        req = 1'b1; rw = 1'b1; byte_acc = 1'b0; addr = 16'h0020; wdata = 16'hA55A;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        chk("wait_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_we", {lb_we, ub_we}, 2'b00);
        chk("midrst_rdata", rdata, 16'h0);
        chk("midrst_addr", lb_addr, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_done", done, 1'b0);
        chk("midrst_lb_we_cnt", mon_lb - lb0, 1);
        ref_mem[16'h0020] = 8'h5A;
        ref_mem[16'h0021] = 8'hA5;
        exp_rdata = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0);

        access(1'b1, 1'b0, BKPT, 16'h7E57, 1'b0);
        access(1'b0, 1'b0, BKPT, 16'h0000, 1'b0);

        for (int i = 0; i < 60; i++) begin
            rr = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0)
                ra = 16'hFFF8 + 16'($urandom_range(0, 7));
            else
                ra = 16'($urandom_range(0, 63));
            access(rr, rb, ra, 16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
